// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter and sequencer for a single-ported word memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_resp_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       lat_we;
    logic       lat_data;
    logic       grant_data;
    logic       accept;
`ifdef MEM_ARB_RR_EN
    logic       last_grant;   // 1 = data port won the previous accept
`endif

    always_comb begin
        grant_data = d_req_valid;
`ifdef MEM_ARB_RR_EN
        if (d_req_valid && if_req_valid)
            grant_data = !last_grant;
`endif
    end

    assign accept       = (state == IDLE) && (d_req_valid || if_req_valid);
    assign d_req_ready  = accept && grant_data;
    assign if_req_ready = accept && !grant_data;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_we        <= 1'b0;
            lat_data      <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            if_resp_valid <= 1'b0;
            if_rdata      <= '0;
            if_err        <= 1'b0;
            d_resp_valid  <= 1'b0;
            d_rdata       <= '0;
            d_err         <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_data  <= grant_data;
                        lat_we    <= grant_data && d_we;
                        mem_addr  <= grant_data ? d_addr : if_addr;
                        mem_wdata <= grant_data ? d_wdata : '0;
                        mem_be    <= grant_data ? d_be : 4'hF;
                        mem_read  <= !(grant_data && d_we);
                        mem_write <= grant_data && d_we;
`ifdef MEM_ARB_RR_EN
                        last_grant <= grant_data;
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // Completion wins over timeout when both land in the same cycle
                    if (mem_ready) begin
                        if (lat_data) begin
                            d_resp_valid <= 1'b1;
                            d_rdata      <= lat_we ? '0 : mem_rdata;
                            d_err        <= 1'b0;
                        end else begin
                            if_resp_valid <= 1'b1;
                            if_rdata      <= mem_rdata;
                            if_err        <= 1'b0;
                        end
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        if (lat_data) begin
                            d_resp_valid <= 1'b1;
                            d_rdata      <= '0;
                            d_err        <= 1'b1;
                        end else begin
                            if_resp_valid <= 1'b1;
                            if_rdata      <= '0;
                            if_err        <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if_resp_valid <= 1'b0;
                    d_resp_valid  <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a word-array reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_resp_valid, if_err;
    logic [31:0] if_rdata;
    logic        d_req_valid = 1'b0, d_req_ready;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic        d_resp_valid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        busy;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_be(d_be),
        .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory block model: registered ready/data one cycle after a sampled strobe
    logic [31:0] tb_mem [256];
    logic        stall = 1'b0, stray = 1'b0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    function automatic logic [31:0] byte_write(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        mem_ready <= stray;
        if (pl_en)
            tb_mem[pl_idx] <= pl_data;
        else if ((mem_read || mem_write) && !stall) begin
            mem_ready <= 1'b1;
            if (mem_read)  mem_rdata <= tb_mem[mem_addr[9:2]];
            if (mem_write) tb_mem[mem_addr[9:2]] <= byte_write(tb_mem[mem_addr[9:2]], mem_wdata, mem_be);
        end
    end

    int resp_cnt = 0;
    always @(negedge clk) resp_cnt <= resp_cnt + int'(if_resp_valid) + int'(d_resp_valid);

    // Reference model
    logic [31:0] ref_mem [256];
    logic        model_last = 1'b0;   // 1 = data port was last granted
    int          n_checks = 0, n_pass = 0;

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (wd & m);
    endfunction

    logic        o_rdy, o_rd, o_wr, o_got, o_err;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    int          o_lat;

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = val; ref_mem[idx] = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Drives one single-requester transaction and records what the DUT did
    task automatic txn(input logic is_d, input logic [31:0] addr, input logic we,
                       input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        if (is_d) begin
            d_req_valid = 1'b1; d_addr = addr; d_we = we; d_wdata = wd; d_be = be;
        end else begin
            if_req_valid = 1'b1; if_addr = addr;
        end
        #1 o_rdy = is_d ? d_req_ready : if_req_ready;
        model_last = is_d;
        @(negedge clk);
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        o_rd = mem_read; o_wr = mem_write; o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata;
        o_got = 1'b0; o_lat = 1; o_rdata = 'x; o_err = 1'bx;
        for (int i = 0; i < 40 && !o_got; i++) begin
            @(negedge clk);
            o_lat++;
            if (is_d ? d_resp_valid : if_resp_valid) begin
                o_got = 1'b1;
                o_rdata = is_d ? d_rdata : if_rdata;
                o_err = is_d ? d_err : if_err;
            end
        end
        if (!o_got) o_lat = -1;
    endtask

    task automatic test_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0) $display("FAIL reset_mem_addr: got %h/%h want 0/0", mem_addr, mem_be); else n_pass++;
        n_checks++; if ({if_resp_valid, d_resp_valid, if_err, d_err} !== 4'h0) $display("FAIL reset_resp: got %b want 0000", {if_resp_valid, d_resp_valid, if_err, d_err}); else n_pass++;
        n_checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata); else n_pass++;
        n_checks++; if ({if_req_ready, d_req_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {if_req_ready, d_req_ready}); else n_pass++;
    endtask

    task automatic test_fetch_read();
        preload(8'h10, 32'hDEADBEEF);
        txn(1'b0, 32'h40, 1'b0, 32'h0, 4'hF);
        n_checks++; if (o_rdy !== 1'b1) $display("FAIL fetch_ready: got %b want 1", o_rdy); else n_pass++;
        n_checks++; if ({o_rd, o_wr} !== 2'b10) $display("FAIL fetch_strobe: got %b want 10", {o_rd, o_wr}); else n_pass++;
        n_checks++; if (o_addr !== 32'h40 || o_be !== 4'hF) $display("FAIL fetch_addr: got %h/%h want 40/f", o_addr, o_be); else n_pass++;
        n_checks++; if (o_lat !== 3) $display("FAIL fetch_latency: got %0d want 3", o_lat); else n_pass++;
        n_checks++; if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) $display("FAIL fetch_rdata: got %h err %b want deadbeef err 0", o_rdata, o_err); else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] exp;
        preload(8'h20, 32'hFFFFFFFF);
        txn(1'b1, 32'h80, 1'b1, 32'h12345678, 4'b0011);
        ref_mem[8'h20] = ref_merge(ref_mem[8'h20], 32'h12345678, 4'b0011);
        n_checks++; if ({o_rd, o_wr} !== 2'b01 || o_be !== 4'b0011) $display("FAIL write_strobe: got rw %b be %b want 01/0011", {o_rd, o_wr}, o_be); else n_pass++;
        n_checks++; if (o_wdata !== 32'h12345678) $display("FAIL write_wdata: got %h want 12345678", o_wdata); else n_pass++;
        n_checks++; if (o_rdata !== 32'h0 || o_err !== 1'b0 || o_lat !== 3) $display("FAIL write_resp: got %h err %b lat %0d want 0/0/3", o_rdata, o_err, o_lat); else n_pass++;
        exp = ref_mem[8'h20];
        txn(1'b1, 32'h80, 1'b0, 32'h0, 4'hF);
        n_checks++; if (o_rdata !== exp || exp !== 32'hFFFF5678) $display("FAIL readback: got %h want %h", o_rdata, exp); else n_pass++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            logic        is_d, we;
            logic [7:0]  idx;
            logic [31:0] wd, exp;
            logic [3:0]  be, exp_be;
            is_d = 1'($urandom_range(0, 1));
            we = is_d && 1'($urandom_range(0, 1));
            idx = 8'($urandom); wd = $urandom; be = 4'($urandom);
            exp_be = is_d ? be : 4'hF;
            exp = we ? 32'h0 : ref_mem[idx];
            if (we) ref_mem[idx] = ref_merge(ref_mem[idx], wd, be);
            txn(is_d, {22'd0, idx, 2'b00}, we, wd, be);
            n_checks++; if (o_rdy !== 1'b1) $display("FAIL rnd%0d_ready: got %b want 1", t, o_rdy); else n_pass++;
            n_checks++; if ({o_rd, o_wr} !== {!we, we}) $display("FAIL rnd%0d_strobe: got %b want %b", t, {o_rd, o_wr}, {!we, we}); else n_pass++;
            n_checks++; if (o_addr !== {22'd0, idx, 2'b00} || o_be !== exp_be) $display("FAIL rnd%0d_addr: got %h/%h want %h/%h", t, o_addr, o_be, {22'd0, idx, 2'b00}, exp_be); else n_pass++;
            n_checks++; if (o_lat !== 3) $display("FAIL rnd%0d_latency: got %0d want 3", t, o_lat); else n_pass++;
            n_checks++; if (o_rdata !== exp || o_err !== 1'b0) $display("FAIL rnd%0d_rdata: got %h err %b want %h err 0", t, o_rdata, o_err, exp); else n_pass++;
        end
    endtask

    task automatic test_contention(input int round);
        logic        exp_d;
        logic [31:0] da, ia, exp;
        int          n;
        da = {22'd0, 8'($urandom), 2'b00};
        ia = {22'd0, 8'($urandom), 2'b00};
`ifdef MEM_ARB_RR_EN
        exp_d = !model_last;
`else
        exp_d = 1'b1;
`endif
        @(negedge clk);
        d_req_valid = 1'b1; d_addr = da; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
        if_req_valid = 1'b1; if_addr = ia;
        #1;
        n_checks++; if ({d_req_ready, if_req_ready} !== {exp_d, !exp_d}) $display("FAIL cont%0d_first: got d/if %b want %b", round, {d_req_ready, if_req_ready}, {exp_d, !exp_d}); else n_pass++;
        model_last = exp_d;
        exp = exp_d ? ref_mem[ia[9:2]] : ref_mem[da[9:2]];
        @(negedge clk);
        if (exp_d) d_req_valid = 1'b0; else if_req_valid = 1'b0;
        n = 1;
        while (n < 20) begin
            #1;
            if (exp_d ? if_req_ready : d_req_ready) break;
            @(negedge clk);
            n++;
        end
        n_checks++; if (n !== 4) $display("FAIL cont%0d_second_accept: got %0d cycles want 4", round, n); else n_pass++;
        model_last = !exp_d;
        @(negedge clk);
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        n = 1;
        while (n < 20 && !(exp_d ? if_resp_valid : d_resp_valid)) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (n !== 3) $display("FAIL cont%0d_second_latency: got %0d want 3", round, n); else n_pass++;
        n_checks++; if ((exp_d ? if_rdata : d_rdata) !== exp) $display("FAIL cont%0d_second_rdata: got %h want %h", round, exp_d ? if_rdata : d_rdata, exp); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [7:0] idx;
        idx = 8'($urandom);
        stall = 1'b1;
        txn(1'b1, {22'd0, idx, 2'b00}, 1'b0, 32'h0, 4'hF);
        stall = 1'b0;
        n_checks++; if (o_lat !== TIMEOUT + 2) $display("FAIL timeout_latency: got %0d want %0d", o_lat, TIMEOUT + 2); else n_pass++;
        n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) $display("FAIL timeout_resp: got err %b rdata %h want 1/0", o_err, o_rdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL timeout_idle: got busy %b want 0", busy); else n_pass++;
        txn(1'b0, {22'd0, idx, 2'b00}, 1'b0, 32'h0, 4'hF);
        n_checks++; if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== ref_mem[idx]) $display("FAIL timeout_recover: got lat %0d err %b rdata %h want 3/0/%h", o_lat, o_err, o_rdata, ref_mem[idx]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int r0;
        stall = 1'b1;
        @(negedge clk);
        d_req_valid = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_be = 4'hF;
        @(negedge clk);
        d_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        model_last = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if ({mem_read, mem_write} !== 2'b00 || mem_addr !== 32'h0) $display("FAIL midrst_mem: got %b %h want 00 0", {mem_read, mem_write}, mem_addr); else n_pass++;
        n_checks++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0 || d_err !== 1'b0 || d_resp_valid !== 1'b0) $display("FAIL midrst_resp: got %h %h %b %b want zeros", d_rdata, if_rdata, d_err, d_resp_valid); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        #1 r0 = resp_cnt;
        repeat (15) @(negedge clk);
        #1;
        n_checks++; if (resp_cnt !== r0) $display("FAIL midrst_no_resp: got %0d responses want 0", resp_cnt - r0); else n_pass++;
        txn(1'b1, 32'h100, 1'b0, 32'h0, 4'hF);
        n_checks++; if (o_lat !== 3 || o_rdata !== ref_mem[8'h40]) $display("FAIL midrst_recover: got lat %0d rdata %h want 3/%h", o_lat, o_rdata, ref_mem[8'h40]); else n_pass++;
    endtask

    task automatic test_stray_ready();
        int r0;
        @(negedge clk);
        #1 r0 = resp_cnt;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (busy !== 1'b0) $display("FAIL stray_busy%0d: got %b want 0", i, busy); else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++; if (resp_cnt !== r0) $display("FAIL stray_no_resp: got %0d responses want 0", resp_cnt - r0); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            preload(8'(i), v);
        end
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1 test_reset();
        test_fetch_read();
        test_write_read();
        test_random();
        test_contention(0);
        test_contention(1);
        test_contention(2);
        test_timeout();
        test_reset_mid();
        test_stray_ready();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-ported word memory.
- Shares the memory between the instruction-fetch port (read-only) and the data load/store port.
- Sequences each transaction as one-cycle command issue, then wait for the memory's registered ready, then one-cycle response pulse to the winning requester.
- Sits between the core's fetch/LSU units and the memory block; one outstanding transaction at a time.

Parameters:
- TIMEOUT, 8, max cycles spent in WAIT before the transaction is aborted with an error response (2..255).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch byte address
- if_resp_valid  out  1  fetch response pulse
- if_rdata  out  32  fetch read data
- if_err  out  1  fetch response is timeout error
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_addr  in  32  data byte address
- d_we  in  1  1 = write, 0 = read
- d_wdata  in  32  write data
- d_be  in  4  write byte enables
- d_resp_valid  out  1  data response pulse
- d_rdata  out  32  data read data (0 for writes)
- d_err  out  1  data response is timeout error
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_be  out  4  memory byte enables
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completion (asserted the cycle after a strobe is sampled)
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (async): state IDLE, all outputs 0, latched request and timeout counter cleared, last_grant = fetch.
- Reset asserted mid-transaction drops it silently; no response is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner's req_ready is driven high combinationally from its req_valid; the loser's ready stays 0.
  - On accept: latch addr, wdata, we and be (fetch: we = 0, be = 4'hF, wdata = 0) plus grant id; go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_read = !we, mem_write = we; mem_addr/mem_wdata/mem_be come from the latched values.
  - Counter cleared; go to WAIT.
- WAIT:
  - Strobes are 0; mem_addr/mem_wdata/mem_be hold their latched values.
  - mem_ready = 1: capture mem_rdata (reads only), err = 0, go to RESP.
  - Otherwise the counter increments. When counter == TIMEOUT-1 without ready: err = 1, rdata = 0, go to RESP.
- RESP (one cycle):
  - The granted port's resp_valid = 1 with registered rdata/err; the other port's resp outputs are 0.
  - Go to IDLE. resp_valid is a single-cycle pulse with no back-pressure.
- Latency: accept edge → ISSUE, then WAIT, then RESP. resp_valid is high in the 3rd cycle after the accept cycle when memory is nominal.
- Throughput: one transaction per 4 cycles.
- Arbitration (default): fixed priority, data over fetch. Fetch is granted only when d_req_valid = 0 in IDLE.
- Requests seen outside IDLE get req_ready = 0. Requesters must hold valid and payload stable until accepted.
- A mem_ready seen in IDLE/ISSUE/RESP is ignored.
- rdata/err outputs hold their last value when resp_valid = 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both ports are valid in IDLE, the port not equal to last_grant wins.
  - last_grant updates on every accept.
  - A single valid requester always wins.
- Undefined: fixed data-over-fetch priority; last_grant register is absent.

Test Plan:
- Fetch read: preload word 0x40 = 0xDEADBEEF; if_req_valid with if_addr = 0x40 → if_req_ready high the same cycle, mem_read pulse 1 cycle later, if_resp_valid 3 cycles after accept with if_rdata = 0xDEADBEEF, if_err = 0.
- Data write then read: d_we = 1, d_addr = 0x80, d_wdata = 0x12345678, d_be = 4'b0011 onto a word of 0xFFFFFFFF → mem_write pulse with mem_be = 0011. A following read of 0x80 returns d_rdata = 0xFFFF5678.
- Contention: both valid in the same IDLE cycle → data granted first, fetch 4 cycles later.
  - With MEM_ARB_RR_EN: alternates fetch, data, fetch on a continuous double request.
- Timeout: memory model holds mem_ready = 0, TIMEOUT = 8 → d_resp_valid with d_err = 1, d_rdata = 0 after 8 WAIT cycles; state returns to IDLE and the next request completes normally.
- Reset mid-op: assert reset_n = 0 during WAIT → all outputs 0 immediately, busy = 0, no resp_valid after release, and a new request completes in nominal latency.
- Stray ready: pulse mem_ready in IDLE → no resp_valid and no state change.
